dual_port_ram_sync_be: RTL and testbench
========================================

# dual_port_ram_sync_be

Parametrised true dual-port RAM with synchronous read, per-byte write enables, selectable read-during-write mode, an optional output pipeline register and address-collision detection. It is the next generation of the team's single-clock dual-port RAM, built for buffering and register-file use where both ports must read and write independently and the read path must map onto registered block-RAM outputs.

## Interface
- ADDR_WIDTH, 6, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- READ_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- OUT_REG, 0, 1 adds an output pipeline stage
- clk  in  1  clock, all activity on rising edge
- reset_n  in  1  asynchronous, active-low reset
- en_a / en_b  in  1  port access enable
- we_a / we_b  in  1  write when en=1; read otherwise
- be_a / be_b  in  NB  byte-lane write enables; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- addr_a / addr_b  in  ADDR_WIDTH  word address
- din_a / din_b  in  DATA_WIDTH  write data
- dout_a / dout_b  out  DATA_WIDTH  read data
- valid_a / valid_b  out  1  dout holds the result of an access issued LAT cycles earlier
- coll  out  1  one-cycle pulse: address collision detected

## Operation
- Access: en=1 on a rising edge. Write: lanes with be=1 updated at addr; lanes with be=0 unchanged. we=1 with be=0 is a legal no-op write that still returns data.
- Every enabled access (read or write) produces one result word and one valid pulse.
- Same-port write result: READ_MODE=0 returns the word before the write; READ_MODE=1 returns the merged word after the write (updated lanes new, others old).
- Cross-port: a read on one port at the address the other port writes in the same cycle always returns the old word, in both modes.
- Write/write collision (both write, same addr, same cycle): per lane, port A wins where be_a=1; port B lanes with be_a=0 are still written.
- coll: registered; asserted the cycle after both en=1, addr_a==addr_b, and (we_a|we_b). Read/read at the same address is not a collision.
- When valid is low, dout holds its previous value (no bubble to zero).
- Memory array is not reset; contents after power-up are undefined. Reset touches only output/pipeline registers.

## Timing
- Latency LAT = 1 + OUT_REG. Access at edge n -> dout/valid at edge n+LAT.
- Full throughput: one access per port per cycle, back-to-back, no stalls, no handshake backpressure.
- Reset (asynchronous assert, synchronous-to-clk deassert by the system): dout_a, dout_b = 0; valid_a, valid_b = 0; coll = 0; every pipeline stage cleared. Accesses in flight at reset are dropped; a write whose edge coincides with reset assertion is not guaranteed.
- First access is sampled on the first rising edge with reset_n=1.
- Address wrap: no wrap logic; all 2**ADDR_WIDTH addresses valid, addr all-ones is the last word.
- OUT_REG=1: the stage-1 and stage-2 valids advance every cycle; no enable on the output stage.

## Test plan
- Reset: reset_n=0 mid-stream with reads pending -> dout_a=dout_b=0, valid=0, coll=0 immediately; no stale valid after release.
- Basic R/W, DATA_WIDTH=16, OUT_REG=0: A writes 0xBEEF to addr 5 be=2'b11; next cycle B reads 5 -> dout_b=0xBEEF, valid_b high exactly 1 cycle after the read.
- Byte enables: addr 9 holds 0x1234; A writes 0xABCD be=2'b10 -> B read returns 0xAB34.
- Read-during-write, addr 3 holds 0x1111, A writes 0x2222: READ_MODE=0 -> dout_a=0x1111; READ_MODE=1 -> dout_a=0x2222; B reading 3 same cycle -> 0x1111 in both modes.
- Collision: A writes 0x00AA be=2'b01, B writes 0x5500 be=2'b11, both to addr 7 -> coll pulses 1 cycle; read of 7 returns 0x55AA. Read/read at addr 7 -> coll stays 0.
- OUT_REG=1 streaming: reads of addr 0..63 back-to-back on both ports -> data at n+2, valid continuous for 64 cycles, addr 63 returns last word, no drops.

Source files
------------

// File: rtl/dual_port_ram_sync_be.sv
// True dual-port RAM with byte-lane writes, selectable read-during-write behaviour,
// optional output register and address-collision flag.
module dual_port_ram_sync_be #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int READ_MODE  = 0,
   parameter int OUT_REG    = 0
) (
   input  logic                             i_clk,
   input  logic                             i_reset_n,
   input  logic                             i_en_a,
   input  logic                             i_we_a,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_be_a,
   input  logic [ADDR_WIDTH-1:0]            i_addr_a,
   input  logic [DATA_WIDTH-1:0]            i_din_a,
   input  logic                             i_en_b,
   input  logic                             i_we_b,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_be_b,
   input  logic [ADDR_WIDTH-1:0]            i_addr_b,
   input  logic [DATA_WIDTH-1:0]            i_din_b,
   output logic [DATA_WIDTH-1:0]            o_dout_a,
   output logic [DATA_WIDTH-1:0]            o_dout_b,
   output logic                             o_valid_a,
   output logic                             o_valid_b,
   output logic                             o_coll
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [DATA_WIDTH-1:0] w_old_a, w_old_b;
   logic [DATA_WIDTH-1:0] w_merge_a, w_merge_b;
   logic [DATA_WIDTH-1:0] w_res_a, w_res_b;
   logic                  w_wr_a, w_wr_b;
   logic                  w_coll;

   logic [DATA_WIDTH-1:0] r_d1_a, r_d1_b;
   logic                  r_v1_a, r_v1_b;
   logic                  r_coll;

   assign w_old_a = r_mem[i_addr_a];
   assign w_old_b = r_mem[i_addr_b];
   assign w_wr_a  = i_en_a & i_we_a;
   assign w_wr_b  = i_en_b & i_we_b;

   always_comb begin
      w_merge_a = w_old_a;
      w_merge_b = w_old_b;
      for (int i = 0; i < NB; i++) begin
         if (i_be_a[i]) w_merge_a[i*BYTE_WIDTH +: BYTE_WIDTH] = i_din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (i_be_b[i]) w_merge_b[i*BYTE_WIDTH +: BYTE_WIDTH] = i_din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // Write-first only ever folds in this port's own write; the other port always sees old data.
   assign w_res_a = (READ_MODE == 1 && w_wr_a) ? w_merge_a : w_old_a;
   assign w_res_b = (READ_MODE == 1 && w_wr_b) ? w_merge_b : w_old_b;

   assign w_coll = i_en_a & i_en_b & (i_addr_a == i_addr_b) & (i_we_a | i_we_b);

   // Port A lanes are written last so they win a same-address write/write collision.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NB; i++) begin
         if (w_wr_b && i_be_b[i])
            r_mem[i_addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      for (int i = 0; i < NB; i++) begin
         if (w_wr_a && i_be_a[i])
            r_mem[i_addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_d1_a <= '0;
         r_d1_b <= '0;
         r_v1_a <= 1'b0;
         r_v1_b <= 1'b0;
         r_coll <= 1'b0;
      end else begin
         r_v1_a <= i_en_a;
         r_v1_b <= i_en_b;
         r_coll <= w_coll;
         if (i_en_a) r_d1_a <= w_res_a;
         if (i_en_b) r_d1_b <= w_res_b;
      end
   end

   assign o_coll = r_coll;

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] r_d2_a, r_d2_b;
         logic                  r_v2_a, r_v2_b;

         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               r_d2_a <= '0;
               r_d2_b <= '0;
               r_v2_a <= 1'b0;
               r_v2_b <= 1'b0;
            end else begin
               r_v2_a <= r_v1_a;
               r_v2_b <= r_v1_b;
               if (r_v1_a) r_d2_a <= r_d1_a;
               if (r_v1_b) r_d2_b <= r_d1_b;
            end
         end

         assign o_dout_a  = r_d2_a;
         assign o_dout_b  = r_d2_b;
         assign o_valid_a = r_v2_a;
         assign o_valid_b = r_v2_b;
      end else begin : g_no_out_reg
         assign o_dout_a  = r_d1_a;
         assign o_dout_b  = r_d1_b;
         assign o_valid_a = r_v1_a;
         assign o_valid_b = r_v1_b;
      end
   endgenerate

endmodule

// File: tb/tb_dual_port_ram_sync_be.sv
// Scoreboard bench: three RAM variants (read-first, write-first, read-first + output reg)
// share one stimulus stream; a behavioural model predicts every port output each cycle.
module tb_dual_port_ram_sync_be;

   localparam int AW = 6;
   localparam int DW = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en_a, en_b, we_a, we_b;
   logic [1:0]  be_a, be_b;
   logic [5:0]  addr_a, addr_b;
   logic [15:0] din_a, din_b;

   logic [15:0] dout  [6];
   logic        valid [6];
   logic        coll  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dual_port_ram_sync_be #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
         .READ_MODE((g == 1) ? 1 : 0), .OUT_REG((g == 2) ? 1 : 0)
      ) u_dut (
         .i_clk(clk), .i_reset_n(rst_n),
         .i_en_a(en_a), .i_we_a(we_a), .i_be_a(be_a), .i_addr_a(addr_a), .i_din_a(din_a),
         .i_en_b(en_b), .i_we_b(we_b), .i_be_b(be_b), .i_addr_b(addr_b), .i_din_b(din_b),
         .o_dout_a(dout[2*g]), .o_dout_b(dout[2*g+1]),
         .o_valid_a(valid[2*g]), .o_valid_b(valid[2*g+1]),
         .o_coll(coll[g])
      );
   end

   typedef struct {
      int          due;
      logic [15:0] d;
      bit          k;
   } exp_t;

   exp_t        q [6][$];
   logic [15:0] mem   [64];
   bit          known [64];
   logic [15:0] last  [6];
   bit          last_k [6];
   bit          exp_coll;
   int          cyc;
   int          n_tests;
   int          n_fail;

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                         input logic [1:0] be);
      logic [15:0] r;
      r = old;
      if (be[0]) r[7:0]  = din[7:0];
      if (be[1]) r[15:8] = din[15:8];
      return r;
   endfunction

   task automatic chk_bit(input string tag, input int idx, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] cyc=%0d observed=%b expected=%b", tag, idx, cyc, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input int idx, input logic [15:0] obs,
                           input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, idx, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      for (int k = 0; k < 6; k++) begin
         if (q[k].size() > 0 && q[k][0].due == cyc) begin
            e = q[k].pop_front();
            chk_bit("valid", k, valid[k], 1'b1);
            if (e.k) chk_word("dout", k, dout[k], e.d);
            last[k]   = e.d;
            last_k[k] = e.k;
         end else begin
            chk_bit("valid_idle", k, valid[k], 1'b0);
            if (last_k[k]) chk_word("dout_hold", k, dout[k], last[k]);
         end
      end
      for (int g = 0; g < 3; g++) chk_bit("coll", g, coll[g], exp_coll);
   endtask

   // Drive one cycle of stimulus, predict its results, then check after the edge.
   task automatic step(input bit ea, input bit wa, input logic [1:0] ba, input logic [5:0] aa,
                       input logic [15:0] da,
                       input bit eb, input bit wb, input logic [1:0] bb, input logic [5:0] ab,
                       input logic [15:0] db);
      logic [15:0] old_a, old_b;
      bit          ka, kb, rm, both_wr;
      int          lat;
      exp_t        e;
      en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
      en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;
      old_a = mem[aa]; ka = known[aa];
      old_b = mem[ab]; kb = known[ab];
      both_wr = ea && wa && eb && wb && (aa == ab);
      for (int g = 0; g < 3; g++) begin
         rm  = (g == 1);
         lat = (g == 2) ? 2 : 1;
         if (ea) begin
            e.due = cyc + lat;
            e.d   = (wa && rm) ? merge(old_a, da, ba) : old_a;
            e.k   = (wa && rm) ? (ka || ba == 2'b11) : ka;
            if (rm && both_wr) e.k = 0;
            q[2*g].push_back(e);
         end
         if (eb) begin
            e.due = cyc + lat;
            e.d   = (wb && rm) ? merge(old_b, db, bb) : old_b;
            e.k   = (wb && rm) ? (kb || bb == 2'b11) : kb;
            if (rm && both_wr) e.k = 0;
            q[2*g+1].push_back(e);
         end
      end
      exp_coll = ea && eb && (aa == ab) && (wa || wb);
      if (eb && wb) begin
         mem[ab]   = merge(mem[ab], db, bb);
         known[ab] = known[ab] || (bb == 2'b11);
      end
      if (ea && wa) begin
         mem[aa]   = merge(mem[aa], da, ba);
         known[aa] = known[aa] || (ba == 2'b11);
      end
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
   endtask

   task automatic idle();
      step(0, 0, 2'b00, 6'd0, 16'h0, 0, 0, 2'b00, 6'd0, 16'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en_a = 0; en_b = 0; we_a = 0; we_b = 0;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk_bit("rst_valid", k, valid[k], 1'b0);
         chk_word("rst_dout", k, dout[k], 16'h0000);
         q[k].delete();
         last[k]   = 16'h0000;
         last_k[k] = 1;
      end
      for (int g = 0; g < 3; g++) chk_bit("rst_coll", g, coll[g], 1'b0);
      exp_coll = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; exp_coll = 0;
      rst_n = 1'b0;
      en_a = 0; en_b = 0; we_a = 0; we_b = 0; be_a = 0; be_b = 0;
      addr_a = 0; addr_b = 0; din_a = 0; din_b = 0;
      for (int i = 0; i < 64; i++) begin
         mem[i]   = 16'h0;
         known[i] = 0;
      end
      #2;
      do_reset();

      // Fill the whole array from both ports at once.
      for (int i = 0; i < 32; i++) begin
         step(1, 1, 2'b11, 6'(i), 16'hA500 ^ 16'(i * 257),
              1, 1, 2'b11, 6'(63 - i), 16'hA500 ^ 16'((63 - i) * 257));
      end
      idle();

      // Basic write then cross-port read.
      step(1, 1, 2'b11, 6'd5, 16'hBEEF, 0, 0, 2'b00, 6'd0, 16'h0);
      step(0, 0, 2'b00, 6'd0, 16'h0,    1, 0, 2'b00, 6'd5, 16'h0);
      idle();

      // Partial byte-lane write.
      step(1, 1, 2'b11, 6'd9, 16'h1234, 0, 0, 2'b00, 6'd0, 16'h0);
      step(1, 1, 2'b10, 6'd9, 16'hABCD, 0, 0, 2'b00, 6'd0, 16'h0);
      step(0, 0, 2'b00, 6'd0, 16'h0,    1, 0, 2'b00, 6'd9, 16'h0);
      idle();

      // Read-during-write, same port and cross port.
      step(1, 1, 2'b11, 6'd3, 16'h1111, 0, 0, 2'b00, 6'd0, 16'h0);
      step(1, 1, 2'b11, 6'd3, 16'h2222, 1, 0, 2'b00, 6'd3, 16'h0);
      idle();

      // Write/write collision, then read-back and read/read at the same address.
      step(1, 1, 2'b01, 6'd7, 16'h00AA, 1, 1, 2'b11, 6'd7, 16'h5500);
      step(1, 0, 2'b00, 6'd7, 16'h0,    0, 0, 2'b00, 6'd0, 16'h0);
      step(1, 0, 2'b00, 6'd7, 16'h0,    1, 0, 2'b00, 6'd7, 16'h0);
      idle();
      idle();

      // Reset with reads still in flight.
      step(1, 0, 2'b00, 6'd10, 16'h0, 1, 0, 2'b00, 6'd11, 16'h0);
      do_reset();
      idle();
      idle();

      // Back-to-back streaming over the full address range on both ports.
      for (int i = 0; i < 64; i++) begin
         step(1, 0, 2'b00, 6'(i), 16'h0, 1, 0, 2'b00, 6'(63 - i), 16'h0);
      end
      idle();
      idle();
      idle();

      // Mixed random traffic.
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              6'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              6'($urandom_range(0, 7)), 16'($urandom));
      end
      idle();
      idle();
      idle();

      for (int k = 0; k < 6; k++) begin
         n_tests++;
         assert (q[k].size() == 0) else begin
            n_fail++;
            $error("FAIL drain[%0d] observed=%0d expected=0 results outstanding", k, q[k].size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
